next_pc_unit: RTL and testbench

- Program-counter register and next-PC selector that consumes the jump address produced by the jump-target calculation stage.
- Drives the fetch PC every cycle.
- Supplies the upper PC nibble that the jump-target stage concatenates into its result.
- Stalls itself for the jump stage's fixed 2-cycle latency before loading a jump target.

---
 rtl/next_pc_unit.sv | 148 ++++++++++++++
 tb/tb_next_pc_unit.sv | 245 ++++++++++++++++++++++++
 2 files changed

// File: rtl/next_pc_unit.sv
// next_pc_unit: fetch program-counter register and next-PC selection.
// Sequential, taken-branch and jump targets are chosen here; a jump parks the
// unit in WAIT until the jump-target stage has produced jump_addr.
// Optional build macro NEXT_PC_ALIGN_CHECK_EN: adds the registered
// 'misaligned' output and forces loaded targets to word alignment.
module next_pc_unit #(
  parameter logic [31:0] RESET_PC     = 32'h0000_0000,
  parameter int unsigned JUMP_LATENCY = 2
) (
  input  logic               clk,
  input  logic               rst,
  input  logic               stall,
  input  logic               is_jump,
  input  logic               is_branch,
  input  logic               branch_taken,
  input  logic signed [31:0] branch_offset,
  input  logic [31:0]        jump_addr,
  output logic [31:0]        pc,
  output logic [3:0]         pc_upper,
  output logic               fetch_valid,
  output logic               jump_busy
`ifdef NEXT_PC_ALIGN_CHECK_EN
  ,
  output logic               misaligned
`endif
);

  typedef enum logic [0:0] {
    S_FETCH = 1'b0,
    S_WAIT  = 1'b1
  } state_t;

  // Counter preload: the load happens on the edge where the counter reads 0,
  // so JUMP_LATENCY-1 decrements plus the load edge give JUMP_LATENCY edges.
  localparam logic [2:0] WAIT_INIT = 3'(JUMP_LATENCY - 1);

  state_t      state, state_n;
  logic [2:0]  cnt, cnt_n;
  logic [31:0] pc_n;
  logic        fv_n;
  logic        busy_n;
  logic [31:0] pc_plus4;
  logic [31:0] br_tgt;

  // Sequential successor; all PC arithmetic wraps modulo 2^32.
  function automatic logic [31:0] seq_target(input logic [31:0] base);
    return base + 32'd4;
  endfunction

  // Taken-branch target: word offset scaled to bytes, top two offset bits
  // fall off the shift without any overflow indication.
  function automatic logic [31:0] branch_target(input logic [31:0]        base,
                                                input logic signed [31:0] off);
    logic signed [31:0] off_bytes;
    off_bytes = off <<< 2;
    return base + 32'd4 + $unsigned(off_bytes);
  endfunction

  // Address actually loaded into pc for a jump/branch target.
  function automatic logic [31:0] load_addr(input logic [31:0] tgt);
`ifdef NEXT_PC_ALIGN_CHECK_EN
    return {tgt[31:2], 2'b00};
`else
    return tgt;
`endif
  endfunction

  assign pc_plus4 = seq_target(pc);
  assign pc_upper = pc_plus4[31:28];
  assign br_tgt   = branch_target(pc, branch_offset);

`ifdef NEXT_PC_ALIGN_CHECK_EN
  logic mis_n;
`endif

  // Next-state, next-PC and status selection.
  always_comb begin
    state_n = state;
    cnt_n   = cnt;
    pc_n    = pc;
    fv_n    = fetch_valid;
    busy_n  = jump_busy;
`ifdef NEXT_PC_ALIGN_CHECK_EN
    mis_n   = 1'b0;
`endif
    case (state)
      S_FETCH: begin
        if (!fetch_valid) begin
          fv_n = 1'b1;
        end else if (stall) begin
          pc_n = pc;
        end else if (is_jump) begin
          state_n = S_WAIT;
          cnt_n   = WAIT_INIT;
          fv_n    = 1'b0;
          busy_n  = 1'b1;
        end else if (is_branch && branch_taken) begin
          pc_n = load_addr(br_tgt);
`ifdef NEXT_PC_ALIGN_CHECK_EN
          mis_n = |br_tgt[1:0];
`endif
        end else begin
          pc_n = pc_plus4;
        end
      end
      S_WAIT: begin
        if (cnt != 3'd0) begin
          cnt_n = cnt - 3'd1;
        end else begin
          pc_n    = load_addr(jump_addr);
          state_n = S_FETCH;
          fv_n    = 1'b1;
          busy_n  = 1'b0;
`ifdef NEXT_PC_ALIGN_CHECK_EN
          mis_n   = |jump_addr[1:0];
`endif
        end
      end
      default: begin
        state_n = S_FETCH;
      end
    endcase
  end

  // State, counter, PC and status registers; reset abandons any pending jump.
  always_ff @(posedge clk) begin
    if (rst) begin
      state       <= S_FETCH;
      cnt         <= 3'd0;
      pc          <= RESET_PC;
      fetch_valid <= 1'b0;
      jump_busy   <= 1'b0;
`ifdef NEXT_PC_ALIGN_CHECK_EN
      misaligned  <= 1'b0;
`endif
    end else begin
      state       <= state_n;
      cnt         <= cnt_n;
      pc          <= pc_n;
      fetch_valid <= fv_n;
      jump_busy   <= busy_n;
`ifdef NEXT_PC_ALIGN_CHECK_EN
      misaligned  <= mis_n;
`endif
    end
  end

endmodule

// File: tb/tb_next_pc_unit.sv
// tb_next_pc_unit: scoreboard bench for next_pc_unit (default parameters).
module tb_next_pc_unit;

  logic               clk = 1'b0;
  logic               rst = 1'b0;
  logic               stall = 1'b0;
  logic               is_jump = 1'b0;
  logic               is_branch = 1'b0;
  logic               branch_taken = 1'b0;
  logic signed [31:0] branch_offset = '0;
  logic [31:0]        jump_addr = '0;
  logic [31:0]        pc;
  logic [3:0]         pc_upper;
  logic               fetch_valid;
  logic               jump_busy;
  logic               mis;

  localparam logic [31:0] G = 32'hDEAD_BEE0;

  next_pc_unit dut (
    .clk          (clk),
    .rst          (rst),
    .stall        (stall),
    .is_jump      (is_jump),
    .is_branch    (is_branch),
    .branch_taken (branch_taken),
    .branch_offset(branch_offset),
    .jump_addr    (jump_addr),
    .pc           (pc),
    .pc_upper     (pc_upper),
    .fetch_valid  (fetch_valid),
`ifdef NEXT_PC_ALIGN_CHECK_EN
    .jump_busy    (jump_busy),
    .misaligned   (mis)
`else
    .jump_busy    (jump_busy)
`endif
  );

`ifndef NEXT_PC_ALIGN_CHECK_EN
  assign mis = 1'b0;
`endif

  always #5 clk = ~clk;

  typedef struct packed {
    logic [31:0] pc;
    logic        fv;
    logic        busy;
    logic [3:0]  upper;
    logic        mis;
  } obs_t;

  obs_t  exp_q[$];
  obs_t  act_q[$];
  string name_q[$];
  int    vectors = 0;
  int    miscompares = 0;

  // Drive one cycle of stimulus, queue its expected result, sample after the edge.
  task automatic apply(input string nm, input logic r, input logic st, input logic j,
                       input logic b, input logic t, input logic [31:0] off,
                       input logic [31:0] ja, input logic [31:0] epc,
                       input logic efv, input logic ebusy, input logic emis);
    obs_t e, a;
    logic [31:0] p4;
    rst = r; stall = st; is_jump = j; is_branch = b; branch_taken = t;
    branch_offset = off; jump_addr = ja;
    p4 = epc + 32'd4;
    e.pc = epc; e.fv = efv; e.busy = ebusy; e.upper = p4[31:28]; e.mis = emis;
    exp_q.push_back(e);
    name_q.push_back(nm);
    @(posedge clk);
    #1;
    a.pc = pc; a.fv = fetch_valid; a.busy = jump_busy; a.upper = pc_upper; a.mis = mis;
    act_q.push_back(a);
  endtask

  // Jump from cur to tgt; is_jump held stable through WAIT, jump_addr only
  // valid on the load edge.
  task automatic do_jump(input string nm, input logic [31:0] cur, input logic [31:0] tgt);
    logic [31:0] epc;
    logic        emis;
`ifdef NEXT_PC_ALIGN_CHECK_EN
    epc  = {tgt[31:2], 2'b00};
    emis = |tgt[1:0];
`else
    epc  = tgt;
    emis = 1'b0;
`endif
    apply({nm, "_acc"}, 0, 0, 1, 0, 0, 0, G,   cur, 0, 1, 0);
    apply({nm, "_w1"},  0, 0, 1, 0, 0, 0, G,   cur, 0, 1, 0);
    apply({nm, "_ld"},  0, 0, 1, 0, 0, 0, tgt, epc, 1, 0, emis);
  endtask

  task automatic test_reset();
    obs_t e, a; string nm;
    apply("rst",      1, 0, 0, 0, 0, 0, 0, 32'h0, 0, 0, 0);
    apply("rst_wins", 1, 1, 1, 1, 1, 5, G, 32'h0, 0, 0, 0);
    apply("rel_fv",   0, 0, 1, 1, 1, 5, G, 32'h0, 1, 0, 0);
    apply("seq4",     0, 0, 0, 0, 0, 0, G, 32'h4, 1, 0, 0);
    apply("seq8",     0, 0, 0, 0, 0, 0, G, 32'h8, 1, 0, 0);
    apply("seq12",    0, 0, 0, 0, 0, 0, G, 32'hC, 1, 0, 0);
    while (exp_q.size() > 0) begin
      e = exp_q.pop_front(); a = act_q.pop_front(); nm = name_q.pop_front();
      vectors++;
      if (a !== e) begin
        miscompares++;
        $display("FAIL %s: got pc=%h fv=%b busy=%b up=%h mis=%b, want pc=%h fv=%b busy=%b up=%h mis=%b",
                 nm, a.pc, a.fv, a.busy, a.upper, a.mis, e.pc, e.fv, e.busy, e.upper, e.mis);
      end
    end
  endtask

  task automatic test_branch();
    obs_t e, a; string nm;
    do_jump("br_ld", 32'hC, 32'h100);
    apply("br_taken",    0, 0, 0, 1, 1, 32'hFFFF_FFFE, G, 32'h0FC, 1, 0, 0);
    do_jump("br_ld2", 32'hFC, 32'h100);
    apply("br_nt",       0, 0, 0, 1, 0, 32'hFFFF_FFFE, G, 32'h104, 1, 0, 0);
    apply("br_pos",      0, 0, 0, 1, 1, 32'h3,         G, 32'h114, 1, 0, 0);
    apply("br_shdrop",   0, 0, 0, 1, 1, 32'h4000_0001, G, 32'h11C, 1, 0, 0);
    apply("taken_no_br", 0, 0, 0, 0, 1, 32'h3,         G, 32'h120, 1, 0, 0);
    apply("jmp_over_br", 0, 0, 1, 1, 1, 32'h3,         G, 32'h120, 0, 1, 0);
    apply("job_w1",      0, 0, 0, 1, 1, 32'h3,         G, 32'h120, 0, 1, 0);
    apply("job_ld",      0, 1, 0, 1, 1, 32'h3, 32'h1000_0020, 32'h1000_0020, 1, 0, 0);
    while (exp_q.size() > 0) begin
      e = exp_q.pop_front(); a = act_q.pop_front(); nm = name_q.pop_front();
      vectors++;
      if (a !== e) begin
        miscompares++;
        $display("FAIL %s: got pc=%h fv=%b busy=%b up=%h mis=%b, want pc=%h fv=%b busy=%b up=%h mis=%b",
                 nm, a.pc, a.fv, a.busy, a.upper, a.mis, e.pc, e.fv, e.busy, e.upper, e.mis);
      end
    end
  endtask

  task automatic test_jump();
    obs_t e, a; string nm;
    apply("j_acc", 0, 0, 1, 0, 0, 0, G,             32'h1000_0020, 0, 1, 0);
    apply("j_w1",  0, 0, 0, 0, 0, 0, G,             32'h1000_0020, 0, 1, 0);
    apply("j_ld",  0, 0, 0, 0, 0, 0, 32'h1000_4000, 32'h1000_4000, 1, 0, 0);
    apply("j_seq", 0, 0, 0, 0, 0, 0, G,             32'h1000_4004, 1, 0, 0);
    while (exp_q.size() > 0) begin
      e = exp_q.pop_front(); a = act_q.pop_front(); nm = name_q.pop_front();
      vectors++;
      if (a !== e) begin
        miscompares++;
        $display("FAIL %s: got pc=%h fv=%b busy=%b up=%h mis=%b, want pc=%h fv=%b busy=%b up=%h mis=%b",
                 nm, a.pc, a.fv, a.busy, a.upper, a.mis, e.pc, e.fv, e.busy, e.upper, e.mis);
      end
    end
  endtask

  task automatic test_stall();
    obs_t e, a; string nm;
    do_jump("st_ld", 32'h1000_4004, 32'h40);
    apply("st_1",    0, 1, 0, 1, 1, 32'h7, G, 32'h40, 1, 0, 0);
    apply("st_2",    0, 1, 0, 0, 0, 0,     G, 32'h40, 1, 0, 0);
    apply("st_3",    0, 1, 0, 0, 0, 0,     G, 32'h40, 1, 0, 0);
    apply("st_rel",  0, 0, 0, 0, 0, 0,     G, 32'h44, 1, 0, 0);
    apply("st_jmp",  0, 1, 1, 0, 0, 0,     G, 32'h44, 1, 0, 0);
    apply("stw_acc", 0, 0, 1, 0, 0, 0,     G, 32'h44, 0, 1, 0);
    apply("stw_w1",  0, 1, 0, 0, 0, 0,     G, 32'h44, 0, 1, 0);
    apply("stw_ld",  0, 1, 0, 0, 0, 0, 32'h200, 32'h200, 1, 0, 0);
    apply("st_hold", 0, 1, 0, 0, 0, 0,     G, 32'h200, 1, 0, 0);
    apply("st_go",   0, 0, 0, 0, 0, 0,     G, 32'h204, 1, 0, 0);
    while (exp_q.size() > 0) begin
      e = exp_q.pop_front(); a = act_q.pop_front(); nm = name_q.pop_front();
      vectors++;
      if (a !== e) begin
        miscompares++;
        $display("FAIL %s: got pc=%h fv=%b busy=%b up=%h mis=%b, want pc=%h fv=%b busy=%b up=%h mis=%b",
                 nm, a.pc, a.fv, a.busy, a.upper, a.mis, e.pc, e.fv, e.busy, e.upper, e.mis);
      end
    end
  endtask

  task automatic test_reset_mid_wait();
    obs_t e, a; string nm;
    apply("rmw_acc", 0, 0, 1, 0, 0, 0, G,       32'h204, 0, 1, 0);
    apply("rmw_w1",  0, 0, 1, 0, 0, 0, G,       32'h204, 0, 1, 0);
    apply("rmw_rst", 1, 0, 1, 0, 0, 0, 32'h300, 32'h0,   0, 0, 0);
    apply("rmw_rel", 0, 0, 0, 0, 0, 0, 32'h300, 32'h0,   1, 0, 0);
    apply("rmw_seq", 0, 0, 0, 0, 0, 0, 32'h300, 32'h4,   1, 0, 0);
    while (exp_q.size() > 0) begin
      e = exp_q.pop_front(); a = act_q.pop_front(); nm = name_q.pop_front();
      vectors++;
      if (a !== e) begin
        miscompares++;
        $display("FAIL %s: got pc=%h fv=%b busy=%b up=%h mis=%b, want pc=%h fv=%b busy=%b up=%h mis=%b",
                 nm, a.pc, a.fv, a.busy, a.upper, a.mis, e.pc, e.fv, e.busy, e.upper, e.mis);
      end
    end
  endtask

  task automatic test_wrap();
    obs_t e, a; string nm;
    do_jump("wr_ld", 32'h4, 32'hFFFF_FFFC);
    apply("wr_seq",  0, 0, 0, 0, 0, 0,             G, 32'h0,         1, 0, 0);
    apply("wr_br0",  0, 0, 0, 1, 1, 32'hFFFF_FFFF, G, 32'h0,         1, 0, 0);
    apply("wr_brng", 0, 0, 0, 1, 1, 32'hFFFF_FFFE, G, 32'hFFFF_FFFC, 1, 0, 0);
    while (exp_q.size() > 0) begin
      e = exp_q.pop_front(); a = act_q.pop_front(); nm = name_q.pop_front();
      vectors++;
      if (a !== e) begin
        miscompares++;
        $display("FAIL %s: got pc=%h fv=%b busy=%b up=%h mis=%b, want pc=%h fv=%b busy=%b up=%h mis=%b",
                 nm, a.pc, a.fv, a.busy, a.upper, a.mis, e.pc, e.fv, e.busy, e.upper, e.mis);
      end
    end
  endtask

  task automatic test_align();
    obs_t e, a; string nm;
    do_jump("al_ld", 32'hFFFF_FFFC, 32'h0000_2006);
`ifdef NEXT_PC_ALIGN_CHECK_EN
    apply("al_next", 0, 0, 0, 0, 0, 0, G, 32'h0000_2008, 1, 0, 0);
`else
    apply("al_next", 0, 0, 0, 0, 0, 0, G, 32'h0000_200A, 1, 0, 0);
`endif
    while (exp_q.size() > 0) begin
      e = exp_q.pop_front(); a = act_q.pop_front(); nm = name_q.pop_front();
      vectors++;
      if (a !== e) begin
        miscompares++;
        $display("FAIL %s: got pc=%h fv=%b busy=%b up=%h mis=%b, want pc=%h fv=%b busy=%b up=%h mis=%b",
                 nm, a.pc, a.fv, a.busy, a.upper, a.mis, e.pc, e.fv, e.busy, e.upper, e.mis);
      end
    end
  endtask

  initial begin
    test_reset();
    test_branch();
    test_jump();
    test_stall();
    test_reset_mid_wait();
    test_wrap();
    test_align();
    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
